// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//
// Prescaled up/down counter with a display window, wrap/compare pulses and a
// one-shot mode that runs from the current count until it lands on cmp_val.
//
// Parameters
//   WIDTH  : count register width in bits (2..32)
//   OUT_W  : width of the display window taken from the top of count (1..WIDTH)
//   PRE_W  : prescaler register width in bits
//
// Ports
//   clk      : single clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : global count enable
//   dir      : 1 = count up, 0 = count down
//   mode     : 0 = free-run, 1 = one-shot
//   start    : one-shot arm pulse
//   load     : synchronous load strobe (beats a step, works regardless of en)
//   load_val : value written to count on load
//   prescale : step every prescale+1 active cycles
//   cmp_val  : compare value for the match pulse / one-shot end point
//   count    : current count register
//   win_out  : upper OUT_W bits of count
//   tick     : registered pulse, one per step
//   wrap     : registered pulse when a step wraps modulo 2^WIDTH
//   match    : registered pulse when a step lands on cmp_val
//   busy     : one-shot run in progress
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH = 24,
  parameter int OUT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic [OUT_W-1:0] win_out,
  output logic             tick,
  output logic             wrap,
  output logic             match,
  output logic             busy
);

  logic [PRE_W-1:0] pre_cnt;
  logic             active;
  logic             pre_hit;
  logic             step;
  logic [WIDTH-1:0] count_next;
  logic             step_wrap;
  logic             step_match;

  always_comb begin
    // In one-shot mode the counter only runs while an armed run is in flight.
    active     = en && (!mode || busy);
    // Exact equality: if prescale drops below pre_cnt mid-period, pre_cnt
    // keeps climbing and wraps around before it matches again.
    pre_hit    = (pre_cnt == prescale);
    // Load pre-empts any step that would otherwise happen this cycle.
    step       = active && !load && pre_hit;
    count_next = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    step_wrap  = dir ? (&count) : (~|count);
    step_match = (count_next == cmp_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      pre_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      match   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // Status pulses describe the step taken on this edge, so they appear
      // together in the following cycle.
      tick  <= step;
      wrap  <= step && step_wrap;
      match <= step && step_match;

      if (load) begin
        count   <= load_val;
        pre_cnt <= '0;
      end else if (active) begin
        if (pre_hit) begin
          count   <= count_next;
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      // Arming is independent of load, so load+start restarts a run from
      // load_val. A step in one-shot mode implies busy, so start is never
      // seen together with the terminating step.
      if (!mode) begin
        busy <= 1'b0;
      end else if (!busy && start) begin
        busy <= 1'b1;
      end else if (step && step_match) begin
        busy <= 1'b0;
      end
    end
  end

  assign win_out = count[WIDTH-1 -: OUT_W];

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;
  localparam int     WIDTH = 24;
  localparam int     OUT_W = 8;
  localparam int     PRE_W = 8;
  localparam longint MOD   = 64'd1 << WIDTH;
  localparam int     PMOD  = 1 << PRE_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0, dir = 1'b0, mode = 1'b0, start = 1'b0, load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] cmp_val = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic [OUT_W-1:0] win_out;
  logic             tick, wrap, match, busy;

  int vectors = 0;
  int miscompares = 0;
  int tick_seen = 0, match_seen = 0, wrap_seen = 0;

  param_counter #(.WIDTH(WIDTH), .OUT_W(OUT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_val(load_val), .prescale(prescale), .cmp_val(cmp_val),
    .count(count), .win_out(win_out), .tick(tick), .wrap(wrap),
    .match(match), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    longint count;
    int     pre;
    bit     busy;
    bit     tick;
    bit     wrap;
    bit     match;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.count = 0; r.pre = 0; r.busy = 0; r.tick = 0; r.wrap = 0; r.match = 0;
    return r;
  endfunction

  // One clock edge of the counter, in plain modular arithmetic.
  function automatic model_t next_state(model_t s);
    model_t n = s;
    bit run = en && (!mode || s.busy);
    bit hit = 0;
    n.tick = 0; n.wrap = 0; n.match = 0;
    if (load) begin
      n.count = longint'(load_val);
      n.pre   = 0;
    end else if (run) begin
      if (s.pre == int'(prescale)) begin
        n.pre   = 0;
        n.count = dir ? (s.count + 1) % MOD : (s.count + MOD - 1) % MOD;
        n.tick  = 1;
        n.wrap  = dir ? (s.count == MOD - 1) : (s.count == 0);
        n.match = (n.count == longint'(cmp_val));
        hit     = n.match;
      end else begin
        n.pre = (s.pre + 1) % PMOD;
      end
    end
    if (!mode) n.busy = 0;
    else if (!s.busy && start) n.busy = 1;
    else if (hit) n.busy = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= next_state(m);
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("count",   longint'(count),   m.count);
    check("win_out", longint'(win_out), m.count >> (WIDTH - OUT_W));
    check("tick",    longint'(tick),    longint'(m.tick));
    check("wrap",    longint'(wrap),    longint'(m.wrap));
    check("match",   longint'(match),   longint'(m.match));
    check("busy",    longint'(busy),    longint'(m.busy));
    if (tick)  tick_seen++;
    if (match) match_seen++;
    if (wrap)  wrap_seen++;
  end

  // Advance n clocks; inputs change 1 time unit after the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int t0, m0, w0;

  initial begin
    // ---- reset ----
    #1 rst = 1'b1;
    cyc(3);
    check("rst_count", longint'(count), 0);
    check("rst_busy",  longint'(busy),  0);
    check("rst_tick",  longint'(tick),  0);
    rst = 1'b0;

    // ---- free-run 65536 steps ----
    prescale = 8'd0; dir = 1'b1; mode = 1'b0; en = 1'b1;
    t0 = tick_seen;
    cyc(65536);
    en = 1'b0;
    check("fr_count",       longint'(count),   64'h010000);
    check("fr_model_count", m.count,           64'h010000);
    check("fr_win",         longint'(win_out), 64'h01);
    check("fr_ticks",       tick_seen - t0,    65536);

    // ---- prescale 3 with enable gap ----
    load = 1'b1; load_val = '0; prescale = 8'd3; en = 1'b1;
    cyc(1);
    load = 1'b0;
    t0 = tick_seen;
    cyc(10);
    check("ps_count10", longint'(count), 2);
    check("ps_ticks10", tick_seen - t0,  2);
    en = 1'b0;
    cyc(5);
    check("ps_hold", longint'(count), 2);
    en = 1'b1;
    cyc(5);
    check("ps_resume", longint'(count), 3);
    cyc(1);
    check("ps_phase_count", longint'(count), 4);
    check("ps_phase_tick",  longint'(tick),  1);

    // ---- wrap up and down ----
    prescale = 8'd0; cmp_val = 24'h123456;
    load = 1'b1; load_val = 24'hFFFFFE;
    cyc(1);
    load = 1'b0;
    check("wr_load", longint'(count), 64'hFFFFFE);
    w0 = wrap_seen;
    cyc(1);
    check("wr_top",      longint'(count), 64'hFFFFFF);
    check("wr_top_wrap", longint'(wrap),  0);
    cyc(1);
    check("wr_zero",      longint'(count), 0);
    check("wr_zero_wrap", longint'(wrap),  1);
    dir = 1'b0;
    cyc(1);
    check("wr_down",      longint'(count), 64'hFFFFFF);
    check("wr_down_wrap", longint'(wrap),  1);
    check("wr_pulses",    wrap_seen - w0,  2);
    en = 1'b0;

    // ---- one-shot to cmp_val=5 ----
    mode = 1'b1; dir = 1'b1; cmp_val = 24'd5; load = 1'b1; load_val = '0;
    cyc(1);
    load = 1'b0; en = 1'b1;
    check("os_idle", longint'(busy), 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("os_armed", longint'(busy), 1);
    t0 = tick_seen; m0 = match_seen;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("os_restart_ignored", longint'(count), 3);
    cyc(8);
    check("os_count",   longint'(count),  5);
    check("os_busy",    longint'(busy),   0);
    check("os_ticks",   tick_seen - t0,   5);
    check("os_matches", match_seen - m0,  1);

    // ---- load+start together, load on a step cycle ----
    load = 1'b1; start = 1'b1; load_val = 24'd100; cmp_val = 24'd103;
    cyc(1);
    load = 1'b0; start = 1'b0;
    check("ls_count", longint'(count), 100);
    check("ls_busy",  longint'(busy),  1);
    check("ls_tick",  longint'(tick),  0);
    cyc(1);
    check("ls_step", longint'(count), 101);
    load = 1'b1; load_val = 24'd50;
    cyc(1);
    load = 1'b0;
    check("lstep_count", longint'(count), 50);
    check("lstep_tick",  longint'(tick),  0);
    mode = 1'b0;
    cyc(1);
    check("mode0_busy", longint'(busy), 0);
    en = 1'b0;

    // ---- async reset in the middle of a one-shot run ----
    mode = 1'b1; en = 1'b1; load = 1'b1; load_val = '0; cmp_val = 24'd20; start = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    cyc(6);
    check("ar_pre_count", longint'(count), 6);
    m0 = match_seen;
    #1 rst = 1'b1;
    #1;
    check("ar_count", longint'(count),   0);
    check("ar_win",   longint'(win_out), 0);
    check("ar_tick",  longint'(tick),    0);
    check("ar_busy",  longint'(busy),    0);
    #1 rst = 1'b0;
    cyc(3);
    check("ar_idle_count", longint'(count), 0);
    check("ar_no_match",   match_seen - m0, 0);

    // ---- randomized traffic ----
    prescale = 8'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 16 == 0) dir = ~dir;
      if ($urandom % 50 == 0) mode = ~mode;
      if ($urandom % 64 == 0) prescale = PRE_W'($urandom % 5);
      en    = ($urandom % 6) != 0;
      start = ($urandom % 6) == 0;
      load  = ($urandom % 40) == 0;
      if (load) begin
        if ($urandom % 2 == 1) load_val = WIDTH'(MOD - 1 - longint'($urandom % 4));
        else                   load_val = WIDTH'($urandom_range(0, 20));
      end
      if ($urandom % 8 == 0) begin
        if (dir) cmp_val = WIDTH'(m.count + longint'($urandom_range(1, 4)));
        else     cmp_val = WIDTH'(m.count + MOD - longint'($urandom_range(1, 4)));
      end
      if ($urandom % 256 == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning count register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter OUT_W, default 8, meaning width of the display window, which is the upper count bits (legal range 1..WIDTH).
REQ-003 The block SHALL have parameter PRE_W, default 8, meaning width of the prescaler register in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: global count enable.
REQ-007 The block SHALL have port dir, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = free-run, 1 = one-shot.
REQ-009 The block SHALL have port start, input, 1 bit: one-shot arm pulse.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: the value loaded on load.
REQ-012 The block SHALL have port prescale, input, PRE_W bits: tick divisor minus 1.
REQ-013 The block SHALL have port cmp_val, input, WIDTH bits: compare value.
REQ-014 The block SHALL have port count, output, WIDTH bits: the current count register.
REQ-015 The block SHALL have port win_out, output, OUT_W bits: count[WIDTH-1 : WIDTH-OUT_W], combinational from count.
REQ-016 The block SHALL have port tick, output, 1 bit: registered 1-cycle pulse on each count step.
REQ-017 The block SHALL have port wrap, output, 1 bit: registered 1-cycle pulse when a step wraps modulo 2^WIDTH.
REQ-018 The block SHALL have port match, output, 1 bit: registered 1-cycle pulse when a step lands on cmp_val.
REQ-019 The block SHALL have port busy, output, 1 bit: one-shot run in progress.

Function
REQ-020 The "active" condition SHALL be: en=1 AND (mode=0 OR busy=1).
REQ-021 The prescaler SHALL behave as follows: while active, pre_cnt increments each cycle; when pre_cnt == prescale, a step occurs and pre_cnt returns to 0 on the same edge; prescale=0 gives a step every active cycle.
REQ-022 When not active, the block SHALL hold pre_cnt and count unchanged and SHALL NOT pulse tick, wrap or match.
REQ-023 On each step, count SHALL become count+1 (dir=1) or count-1 (dir=0), modulo 2^WIDTH; dir is sampled on the step cycle.
REQ-024 The wrap output SHALL pulse in the cycle after a step from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-025 The match output SHALL pulse in the cycle after a step whose new count equals cmp_val; a count already equal to cmp_val without a step SHALL NOT pulse match.
REQ-026 The tick output SHALL pulse in the cycle after every step; tick, wrap and match SHALL be asserted coincidently for one and the same step.
REQ-027 Load SHALL have priority over a step: load=1 sets count<=load_val and pre_cnt<=0, with no tick, wrap or match that cycle, regardless of en.
REQ-028 Start SHALL behave as follows: with mode=1 and busy=0, start=1 sets busy<=1; start while busy=1, or with mode=0, SHALL be ignored.
REQ-029 One-shot termination SHALL be as follows: the step producing match clears busy on the same edge the match pulse is registered; count then holds at cmp_val.
REQ-030 If load and start are both asserted in the same cycle (mode=1), the load SHALL apply and busy SHALL be set; counting resumes from load_val.
REQ-031 Changing mode from 1 to 0 SHALL clear busy on the next edge; busy SHALL always read 0 in free-run mode.
REQ-032 Changing prescale mid-period SHALL take effect at the next comparison; if pre_cnt > prescale, pre_cnt SHALL wrap naturally modulo 2^PRE_W before matching.

Reset
REQ-033 When rst=1, the block SHALL immediately, without waiting for a clock edge, set count=0, pre_cnt=0, tick=0, wrap=0, match=0 and busy=0.
REQ-034 Reset SHALL override load, start and en; the first step after reset deassertion SHALL occur prescale+1 active cycles later.
REQ-035 Reset asserted mid one-shot run SHALL abort the run (busy=0) with no match pulse.

Verification
REQ-036 Free-run with WIDTH=24, prescale=0, dir=1, en=1 for 65536 cycles -> count=0x010000, win_out=0x01, 65536 tick pulses.
REQ-037 Prescale=3 -> tick once every 4 cycles; en low for 5 cycles mid-period -> count and phase held, then resume exactly.
REQ-038 Load 0xFFFFFE, dir=1, prescale=0 -> count 0xFFFFFF, then 0x000000 with a single wrap pulse; dir=0 from 0 -> 0xFFFFFF with a wrap pulse.
REQ-039 One-shot: mode=1, load 0, cmp_val=5, start -> busy high, exactly 5 ticks, a match pulse, busy low, count holds at 5; a second start while busy is ignored.
REQ-040 Simultaneous load+start, and load during a step cycle -> load wins, no tick.
REQ-041 Async rst pulse between clock edges during a one-shot run -> all outputs 0 immediately, no match.
